// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Grant vector bit positions and burst counter sizing live here too.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    // A zero burst limit still needs a one-bit counter to keep ports legal.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Priority select between fetch and data requests, with the burst counter
// that lets a waiting fetch in after MAX_DATA_BURST consecutive data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int CNT_W          = cnt_width(MAX_DATA_BURST)
) (
    input  logic             grant_en,
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] burst_cnt_next
);

    logic fetch_turn;
    logic d_win;
    logic i_win;

    always_comb begin
        fetch_turn = (MAX_DATA_BURST != 0) && (burst_cnt == CNT_W'(MAX_DATA_BURST));
        d_win      = grant_en && d_req && !(i_req && fetch_turn);
        i_win      = grant_en && i_req && !d_win;

        grant        = '0;
        grant[GNT_D] = d_win;
        grant[GNT_I] = i_win;

        // Only data grants that overtake a waiting fetch count toward the limit.
        if (!i_req || i_win) begin
            burst_cnt_next = '0;
        end else if (d_win && (burst_cnt != CNT_W'(MAX_DATA_BURST))) begin
            burst_cnt_next = burst_cnt + 1'b1;
        end else begin
            burst_cnt_next = burst_cnt;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch and data ports.
// One access in flight at a time; a grant in RESP overlaps the response.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_IReq,
    input  logic [ADDR_WIDTH-1:0] i_IAddr,
    output logic                  o_IReady,
    output logic                  o_IValid,
    output logic [DATA_WIDTH-1:0] o_IData,
    input  logic                  i_DReq,
    input  logic [ADDR_WIDTH-1:0] i_DAddr,
    input  logic                  i_DWrEnable,
    input  logic [DATA_WIDTH-1:0] i_DWrData,
    output logic                  o_DReady,
    output logic                  o_DValid,
    output logic [DATA_WIDTH-1:0] o_DRdData,
    output logic                  o_MemReq,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic                  o_MemWrEnable,
    output logic [DATA_WIDTH-1:0] o_MemWrData,
    input  logic                  i_MemAck,
    input  logic [DATA_WIDTH-1:0] i_MemRdData
);

    localparam int CNT_W = cnt_width(MAX_DATA_BURST);

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_W-1:0]      burst_cnt_reg;
    logic [CNT_W-1:0]      burst_cnt_next;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg;
    logic                  cmd_we_reg;
    logic [DATA_WIDTH-1:0] cmd_wdata_reg;
    owner_t                cmd_owner_reg;
    logic [DATA_WIDTH-1:0] i_data_reg;
    logic [DATA_WIDTH-1:0] d_data_reg;
    logic [1:0]            grant;
    logic                  grant_en;
    logic                  mem_done;

    assign grant_en = (state_reg == IDLE) || (state_reg == RESP);
    assign mem_done = (state_reg == BUSY) && i_MemAck;

    mem_arb_select #(
        .MAX_DATA_BURST(MAX_DATA_BURST),
        .CNT_W         (CNT_W)
    ) u_select (
        .grant_en      (grant_en),
        .i_req         (i_IReq),
        .d_req         (i_DReq),
        .burst_cnt     (burst_cnt_reg),
        .grant         (grant),
        .burst_cnt_next(burst_cnt_next)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|grant) state_next = BUSY;
            BUSY:    if (i_MemAck) state_next = RESP;
            RESP:    state_next = (|grant) ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            burst_cnt_reg <= '0;
            cmd_addr_reg  <= '0;
            cmd_we_reg    <= 1'b0;
            cmd_wdata_reg <= '0;
            cmd_owner_reg <= OWN_I;
            i_data_reg    <= '0;
            d_data_reg    <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
            if (grant[GNT_D]) begin
                cmd_addr_reg  <= i_DAddr;
                cmd_we_reg    <= i_DWrEnable;
                cmd_wdata_reg <= i_DWrData;
                cmd_owner_reg <= OWN_D;
            end else if (grant[GNT_I]) begin
                cmd_addr_reg  <= i_IAddr;
                cmd_we_reg    <= 1'b0;
                cmd_wdata_reg <= '0;
                cmd_owner_reg <= OWN_I;
            end
            // Writes report zero on the data port so stale read data never leaks.
            if (mem_done) begin
                if (cmd_owner_reg == OWN_I) begin
                    i_data_reg <= i_MemRdData;
                end else begin
                    d_data_reg <= cmd_we_reg ? '0 : i_MemRdData;
                end
            end
        end
    end

    always_comb begin
        o_MemReq      = (state_reg == BUSY);
        o_MemWrEnable = (state_reg == BUSY) && cmd_we_reg;
        o_IValid      = (state_reg == RESP) && (cmd_owner_reg == OWN_I);
        o_DValid      = (state_reg == RESP) && (cmd_owner_reg == OWN_D);
        o_IReady      = grant[GNT_I];
        o_DReady      = grant[GNT_D];
    end

    assign o_MemAddr   = cmd_addr_reg;
    assign o_MemWrData = cmd_wdata_reg;
    assign o_IData     = i_data_reg;
    assign o_DRdData   = d_data_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a burst-limited instance on a
// wait-state memory model and a strict-priority instance on a zero-wait ack.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = '0;

    logic        i_ready, i_valid, d_ready, d_valid;
    logic [31:0] i_data, d_rd_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rd_data;

    logic        i_ready0, i_valid0, d_ready0, d_valid0;
    logic [31:0] i_data0, d_rd_data0;
    logic        mem_req0, mem_we0;
    logic [31:0] mem_addr0, mem_wdata0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_DATA_BURST(4)) dut (
        .i_Clock(clk), .i_Reset(rst),
        .i_IReq(i_req), .i_IAddr(i_addr), .o_IReady(i_ready), .o_IValid(i_valid), .o_IData(i_data),
        .i_DReq(d_req), .i_DAddr(d_addr), .i_DWrEnable(d_we), .i_DWrData(d_wdata),
        .o_DReady(d_ready), .o_DValid(d_valid), .o_DRdData(d_rd_data),
        .o_MemReq(mem_req), .o_MemAddr(mem_addr), .o_MemWrEnable(mem_we), .o_MemWrData(mem_wdata),
        .i_MemAck(mem_ack), .i_MemRdData(mem_rd_data)
    );

    unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_DATA_BURST(0)) dut0 (
        .i_Clock(clk), .i_Reset(rst),
        .i_IReq(i_req), .i_IAddr(i_addr), .o_IReady(i_ready0), .o_IValid(i_valid0), .o_IData(i_data0),
        .i_DReq(d_req), .i_DAddr(d_addr), .i_DWrEnable(d_we), .i_DWrData(d_wdata),
        .o_DReady(d_ready0), .o_DValid(d_valid0), .o_DRdData(d_rd_data0),
        .o_MemReq(mem_req0), .o_MemAddr(mem_addr0), .o_MemWrEnable(mem_we0), .o_MemWrData(mem_wdata0),
        .i_MemAck(mem_req0), .i_MemRdData(32'h0BAD_F00D)
    );

    // Memory model: acks after mem_wait wait states, unwritten words read a preload pattern.
    int          mem_wait = 0;
    int          wait_cnt;
    logic [31:0] mem [0:255];
    bit          mem_valid [0:255];

    function automatic logic [31:0] preload(input logic [7:0] idx);
        if (idx == 8'd64) return 32'hDEAD_BEEF;
        return {16'hC0DE, 8'h00, idx};
    endfunction

    assign mem_ack     = mem_req && (wait_cnt == mem_wait);
    assign mem_rd_data = mem_valid[mem_addr[9:2]] ? mem[mem_addr[9:2]] : preload(mem_addr[9:2]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (mem_ack && mem_we) begin
            mem[mem_addr[9:2]]       <= mem_wdata;
            mem_valid[mem_addr[9:2]] <= 1'b1;
        end
    end

    // Stimulus helper: issues one data access and waits for its response.
    task automatic data_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                               output logic [31:0] rd, output int req_cycles, output bit ok);
        bit granted;
        granted = 1'b0;
        ok = 1'b0;
        req_cycles = 0;
        rd = '0;
        d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (d_ready) begin granted = 1'b1; break; end
            @(negedge clk);
        end
        if (!granted) begin d_req = 1'b0; return; end
        @(negedge clk);
        d_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (d_valid) begin ok = 1'b1; rd = d_rd_data; break; end
            if (mem_req) req_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, i_valid, d_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got req/we/iv/dv=%b expected 0000", {mem_req, mem_we, i_valid, d_valid});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_data, d_rd_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got idata=%h drd=%h expected 0", i_data, d_rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_ready, d_ready} !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready got %b expected 00", {i_ready, d_ready});
        end
        $display("reset: done");
    endtask

    task automatic test_single_fetch();
        mem_wait = 0;
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_ready_c0 got %b expected 10", {i_ready, d_ready});
        end
        @(negedge clk);
        i_req = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_addr, i_ready} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL fetch_cmd_c1 got req=%b we=%b addr=%h rdy=%b expected 1 0 00000100 0",
                     mem_req, mem_we, mem_addr, i_ready);
        end
        @(negedge clk);
        checks++;
        if ({i_valid, i_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL fetch_valid_c2 got v=%b data=%h expected 1 deadbeef", i_valid, i_data);
        end
        @(negedge clk);
        checks++;
        if ({i_valid, i_data, mem_req} !== {1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL fetch_hold_c3 got v=%b data=%h req=%b expected 0 deadbeef 0", i_valid, i_data, mem_req);
        end
        $display("single_fetch: addr=%h data=%h", 32'h100, i_data);
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int          rc;
        bit          ok;
        mem_wait = 2;
        data_access(32'h100, 1'b0, 32'h0, rd, rc, ok);
        checks++;
        if (!ok || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL data_read_pre got ok=%0d data=%h expected 1 deadbeef", ok, rd);
        end
        $display("data_read: addr=00000100 data=%h req_cycles=%0d", rd, rc);
        // Write, then scramble the payload to show the command is registered.
        d_req = 1'b1; d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready got %b expected 1", d_ready);
        end
        @(negedge clk);
        d_req = 1'b0; d_addr = 32'hFFFF_FFF0; d_we = 1'b0; d_wdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'h1234_5678}) begin
                errors++;
                $display("FAIL write_hold_%0d got req=%b we=%b addr=%h wd=%h expected 1 1 00000040 12345678",
                         c, mem_req, mem_we, mem_addr, mem_wdata);
            end
            @(negedge clk);
        end
        checks++;
        if ({d_valid, d_rd_data, mem_req} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL write_resp got v=%b rd=%h req=%b expected 1 00000000 0", d_valid, d_rd_data, mem_req);
        end
        $display("data_write: addr=00000040 data=12345678 rd=%h", d_rd_data);
        data_access(32'h40, 1'b0, 32'h0, rd, rc, ok);
        checks++;
        if (!ok || rd !== 32'h1234_5678 || rc != 3) begin
            errors++;
            $display("FAIL read_back got ok=%0d data=%h req_cycles=%0d expected 1 12345678 3", ok, rd, rc);
        end
        $display("data_read: addr=00000040 data=%h req_cycles=%0d", rd, rc);
    endtask

    task automatic test_contention();
        string seq;
        int    n, both_hi, i0_grants;
        bit    found;
        seq = ""; n = 0; both_hi = 0; i0_grants = 0; found = 1'b0;
        repeat (3) @(negedge clk);
        mem_wait = 0;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1;
            if (i_ready && d_ready) both_hi++;
            if (d_ready) begin seq = {seq, "D"}; n++; end
            else if (i_ready) begin seq = {seq, "I"}; n++; end
            if (i_ready0) i0_grants++;
            @(negedge clk);
        end
        checks++;
        if (seq != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL burst_seq got %s expected DDDDIDDDDI", seq);
        end
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL one_ready got %0d double-ready cycles expected 0", both_hi);
        end
        checks++;
        if (i0_grants != 0) begin
            errors++;
            $display("FAIL strict_no_fetch got %0d fetch grants expected 0", i0_grants);
        end
        $display("contention: seq=%s strict_fetch_grants=%0d", seq, i0_grants);
        d_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (i_ready0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL strict_fetch_after_drop got no IReady expected IReady within 2 cycles");
        end
        @(negedge clk);
        i_req = 1'b0;
        repeat (4) @(negedge clk);
        $display("strict_release: fetch_granted=%0d", found);
    endtask

    task automatic test_back_to_back();
        bit          rdy_exp [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit          val_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] dat_exp [7] = '{32'h0, 32'h0, 32'hC0DE_0000, 32'h0, 32'hC0DE_0001, 32'h0, 32'hC0DE_0002};
        logic [31:0] adr_exp [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0};
        int          na;
        logic        rdy;
        na = 0;
        mem_wait = 0;
        i_req = 1'b1; i_addr = 32'h0;
        for (int c = 0; c < 7; c++) begin
            #1;
            rdy = i_ready;
            checks++;
            if ({i_ready, i_valid} !== {rdy_exp[c], val_exp[c]}) begin
                errors++;
                $display("FAIL b2b_c%0d got rdy=%b v=%b expected %b %b", c, i_ready, i_valid, rdy_exp[c], val_exp[c]);
            end
            if (val_exp[c] && i_data !== dat_exp[c]) begin
                checks++;
                errors++;
                $display("FAIL b2b_data_c%0d got %h expected %h", c, i_data, dat_exp[c]);
            end else if (val_exp[c]) begin
                checks++;
            end
            if ((c % 2) == 1) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, adr_exp[c]}) begin
                    errors++;
                    $display("FAIL b2b_addr_c%0d got req=%b addr=%h expected 1 %h", c, mem_req, mem_addr, adr_exp[c]);
                end
            end
            $display("b2b: cycle=%0d ready=%b valid=%b data=%h", c, i_ready, i_valid, i_data);
            @(negedge clk);
            if (rdy) begin
                na++;
                if (na < 3) i_addr = 32'(4 * na);
                else i_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int  nv;
        bit  got;
        nv = 0; got = 1'b0;
        repeat (2) @(negedge clk);
        mem_wait = 5;
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b expected 1", i_ready);
        end
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, i_valid, d_valid} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_outputs got req=%b addr=%h iv=%b dv=%b expected 0 00000000 0 0",
                     mem_req, mem_addr, i_valid, d_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (i_valid || d_valid) nv++;
            @(negedge clk);
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL abort_no_valid got %0d valid cycles expected 0", nv);
        end
        $display("reset_mid: aborted, spurious_valids=%0d", nv);
        mem_wait = 0;
        i_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (i_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        i_req = 1'b0;
        if (got) begin
            got = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (i_valid) begin got = 1'b1; break; end
                @(negedge clk);
            end
        end
        checks++;
        if (!got || i_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL refetch got done=%0d data=%h expected 1 deadbeef", got, i_data);
        end
        $display("reset_mid: refetch data=%h", i_data);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port memory bus between the processor's instruction-fetch port and data port, so ProcessorPP/ProcessorSC can run from a unified RAM instead of separate ROM and RAM. Each port uses a request/ready/valid handshake; the memory side uses a request/acknowledge handshake with variable wait states. Sits between the CPU core and the memory in the top-level wrapper. Data accesses have priority, and a burst limit prevents instruction fetches from starving.

## Interface
- DATA_WIDTH, 32, data bus width (fetch and data ports, memory)
- ADDR_WIDTH, 32, address width
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending; 0 = strict data priority
- i_Clock  in  1  clock, rising edge
- i_Reset  in  1  reset; asynchronous, active-high
- i_IReq  in  1  fetch request
- i_IAddr  in  ADDR_WIDTH  fetch address
- o_IReady  out  1  fetch request accepted this cycle
- o_IValid  out  1  fetch data valid (one-cycle pulse)
- o_IData  out  DATA_WIDTH  fetch data
- i_DReq  in  1  data request
- i_DAddr  in  ADDR_WIDTH  data address
- i_DWrEnable  in  1  1 = write, 0 = read
- i_DWrData  in  DATA_WIDTH  write data
- o_DReady  out  1  data request accepted this cycle
- o_DValid  out  1  data access complete (read data valid, or write done)
- o_DRdData  out  DATA_WIDTH  read data; 0 for writes
- o_MemReq  out  1  memory command valid
- o_MemAddr  out  ADDR_WIDTH  memory address
- o_MemWrEnable  out  1  memory write
- o_MemWrData  out  DATA_WIDTH  memory write data
- i_MemAck  in  1  memory completes the command; i_MemRdData valid in the same cycle
- i_MemRdData  in  DATA_WIDTH  memory read data

## Operation
- **States:** IDLE, BUSY, RESP.
- **Grants:**
  - Grants are made only in IDLE or RESP.
  - o_IReady and o_DReady are combinational from the requests, the state and the burst counter. At most one is high per cycle.
  - On a grant, the command (address, write enable, write data, owner) is registered and the FSM moves to BUSY.
- **Priority:**
  - If both ports request, data wins, unless burst_cnt == MAX_DATA_BURST and MAX_DATA_BURST != 0; then fetch wins.
  - burst_cnt increments on each data grant made while i_IReq=1, saturating at MAX_DATA_BURST.
  - burst_cnt clears on a fetch grant, or in any cycle with i_IReq=0.
- **BUSY:**
  - o_MemReq=1, driven with the registered command. The command is held stable until i_MemAck.
  - On i_MemAck, i_MemRdData is captured into the owner's output register (0 for writes) and the FSM moves to RESP.
- **RESP:**
  - The owner's o_xValid=1 for exactly one cycle.
  - A new grant may be made in the same cycle; if one is made, go to BUSY, otherwise go to IDLE.
- **Requester rules:**
  - Request and payload are held stable until the matching Ready.
  - After Ready, a requester may drop or change its request.
  - Each port has at most one access outstanding; a new request before the previous Valid is permitted but not granted before RESP.
- **o_IData / o_DRdData** hold their last value between Valid pulses.

## Timing
- Reset values: state IDLE, burst_cnt 0, o_MemReq 0, o_MemWrEnable 0, o_MemAddr 0, o_MemWrData 0, o_IValid 0, o_DValid 0, o_IData 0, o_DRdData 0.
- Latency: grant in cycle N, o_MemReq in N+1, i_MemAck in N+1+W (W wait states, W ≥ 0), Valid in N+2+W.
- Throughput with W=0: one access every 2 cycles (grant in RESP overlaps the response).
- o_IReady and o_DReady are low in BUSY, regardless of requests.
- i_MemAck is ignored outside BUSY.
- Reset asserted mid-access:
  - Outputs are forced to reset values immediately (asynchronous).
  - No Valid is issued for the aborted access.
  - The memory must tolerate an abandoned o_MemReq.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}
  - owner enum {OWN_I, OWN_D}
- Optional sub-module mem_arb_select: combinational priority and burst logic producing the grant vector. The FSM, command registers and response registers stay in the top module.

## Test plan
- Single fetch, W=0: i_IReq=1, i_IAddr=0x100, memory returns 0xDEADBEEF → o_IReady in cycle 0, o_MemReq/o_MemAddr=0x100 in cycle 1, o_IValid=1 with o_IData=0xDEADBEEF in cycle 2.
- Data write then read, W=2: write 0x12345678 to 0x40, then read 0x40 → o_MemReq held 3 cycles with stable address and data; o_DValid with o_DRdData=0 after the write; read returns 0x12345678.
- Contention, MAX_DATA_BURST=4: both ports request continuously → grant sequence D,D,D,D,I,D,D,D,D,I; never two Ready signals in one cycle.
- MAX_DATA_BURST=0 with continuous i_DReq → fetch is never granted. Drop i_DReq → fetch is granted in the next IDLE/RESP cycle.
- Back-to-back, W=0: fetches to 0x0, 0x4, 0x8 → a new grant in each RESP cycle, o_IValid every second cycle.
- Reset asserted in BUSY with W=5 → o_MemReq=0 immediately, no o_IValid/o_DValid; after release, a fresh fetch completes normally.
